// File: rtl/axi_log_pkg.sv
// Shared definitions for the AXI BRAM logger and its readout path:
// entry field positions, the decoded entry record and the reader FSM states.
package axi_log_pkg;

    localparam int TS_W    = 32;
    localparam int ADDR_W  = 32;
    localparam int ID_W    = 8;
    localparam int LEN_W   = 8;
    localparam int ENTRY_W = 96;

    // Field positions inside one logged entry; anything above LEN is unused.
    localparam int TS_LOW   = 0;
    localparam int ADDR_LOW = TS_LOW + TS_W;
    localparam int ID_LOW   = ADDR_LOW + ADDR_W;
    localparam int LEN_LOW  = ID_LOW + ID_W;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } log_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    function automatic log_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        log_entry_t e;
        e.ts   = raw[TS_LOW   +: TS_W];
        e.addr = raw[ADDR_LOW +: ADDR_W];
        e.id   = raw[ID_LOW   +: ID_W];
        e.len  = raw[LEN_LOW  +: LEN_W];
        return e;
    endfunction

endpackage

// File: rtl/bram_port.sv
// Port of a true-dual-port BRAM as seen from the controller side.
interface BramPort #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    Clk_C;
    logic                    Rst_R;
    logic                    En_S;
    logic [DATA_WIDTH/8-1:0] WrEn_S;
    logic [ADDR_WIDTH-1:0]   Addr_S;
    logic [DATA_WIDTH-1:0]   Rd_D;
    logic [DATA_WIDTH-1:0]   Wr_D;

    modport Master (
        output Clk_C, Rst_R, En_S, WrEn_S, Addr_S, Wr_D,
        input  Rd_D
    );

    modport Slave (
        input  Clk_C, Rst_R, En_S, WrEn_S, Addr_S, Wr_D,
        output Rd_D
    );
endinterface

// File: rtl/log_entry_fifo.sv
// Two-deep first-word-fall-through register buffer for decoded log entries.
// The head entry is presented combinationally and held until popped.
module log_entry_fifo
    import axi_log_pkg::*;
(
    input  logic       Clk_CI,
    input  logic       Rst_RI,
    input  logic       Flush_SI,
    input  logic       Push_SI,
    input  log_entry_t PushEntry_DI,
    input  logic       PushLast_SI,
    input  logic       Pop_SI,
    output log_entry_t PopEntry_DO,
    output logic       PopLast_SO,
    output logic       Full_SO,
    output logic       Empty_SO,
    output logic [1:0] Count_SO
);

    log_entry_t entry_q [2];
    logic [1:0] last_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        do_pop  = Pop_SI && (count_q != 2'd0);
        do_push = Push_SI && ((count_q != 2'd2) || do_pop);
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            last_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (Flush_SI) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= PushEntry_DI;
                last_q[wr_ptr_q]  <= PushLast_SI;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign PopEntry_DO = entry_q[rd_ptr_q];
    assign PopLast_SO  = last_q[rd_ptr_q];
    assign Full_SO     = (count_q == 2'd2);
    assign Empty_SO    = (count_q == 2'd0);
    assign Count_SO    = count_q;

endmodule

// File: rtl/axi_log_reader.sv
// Reads N logged entries out of the logger BRAM (port B) and streams them as
// decoded records. Stream handshake: a beat transfers in a cycle where
// EntryValid_SO and EntryReady_SI are both high; once valid is raised the
// fields hold steady until that transfer.
module axi_log_reader
    import axi_log_pkg::*;
#(
    parameter int  AXI_ADDR_BITW     = 32,
    parameter int  AXI_ID_BITW       = 8,
    parameter int  AXI_LEN_BITW      = 8,
    parameter int  TIMESTAMP_BITW    = 32,
    parameter int  LOGGING_DATA_BITW = 96,
    parameter int  NUM_SER_BRAMS     = 12,
    localparam int CAPACITY          = 1024 * NUM_SER_BRAMS,
    localparam int CNT_W             = $clog2(CAPACITY) + 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      Start_SI,
    input  logic [CNT_W-1:0]          NumEntries_DI,
    input  logic                      Clear_SI,
    output logic                      Busy_SO,
    output logic                      Done_SO,
    BramPort.Master                   Bram_PM,
    output logic                      EntryValid_SO,
    input  logic                      EntryReady_SI,
    output logic                      EntryLast_SO,
    output logic [TIMESTAMP_BITW-1:0] EntryTs_DO,
    output logic [AXI_ADDR_BITW-1:0]  EntryAddr_DO,
    output logic [AXI_ID_BITW-1:0]    EntryId_DO,
    output logic [AXI_LEN_BITW-1:0]   EntryLen_DO,
    output logic [1:0]                State_SO
);

    localparam int ADDR_PAD = 32 - CNT_W - 2;

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] issue_cnt_q;
    logic             inflight_q;
    logic             inflight_last_q;

    logic             accept;
    logic             issue;
    logic             pop;
    logic             flush;
    logic             is_last_idx;
    logic [2:0]       occ_after;

    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    log_entry_t       head_entry;
    logic             head_last;
    log_entry_t       rd_entry;

    always_comb begin
        accept      = (state_q == ST_IDLE) && Start_SI;
        flush       = Clear_SI && (state_q != ST_IDLE);
        pop         = !fifo_empty && EntryReady_SI;
        // Buffer slots already spoken for once this cycle's pop is accounted.
        occ_after   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        is_last_idx = (issue_cnt_q == num_q - CNT_W'(1));
        issue       = (state_q == ST_FETCH) && !Clear_SI && (!fifo_full || pop)
                      && (occ_after < 3'd2) && (issue_cnt_q != num_q);

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start_SI) begin
                    state_d = (NumEntries_DI == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (Clear_SI)                  state_d = ST_IDLE;
                else if (issue && is_last_idx) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (Clear_SI)                state_d = ST_IDLE;
                else if (occ_after == 3'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q         <= ST_IDLE;
            num_q           <= '0;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_q       <= NumEntries_DI;
                issue_cnt_q <= '0;
            end else if (issue) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            // One-cycle BRAM latency: at most one read is ever in flight.
            inflight_q      <= issue;
            inflight_last_q <= issue && is_last_idx;
        end
    end

    assign rd_entry = unpack_entry(Bram_PM.Rd_D[LOGGING_DATA_BITW-1:0]);

    log_entry_fifo u_fifo (
        .Clk_CI       (Clk_CI),
        .Rst_RI       (Rst_RI),
        .Flush_SI     (flush),
        .Push_SI      (inflight_q && !flush),
        .PushEntry_DI (rd_entry),
        .PushLast_SI  (inflight_last_q),
        .Pop_SI       (pop),
        .PopEntry_DO  (head_entry),
        .PopLast_SO   (head_last),
        .Full_SO      (fifo_full),
        .Empty_SO     (fifo_empty),
        .Count_SO     (fifo_count)
    );

    assign Bram_PM.Clk_C  = Clk_CI;
    assign Bram_PM.Rst_R  = Rst_RI;
    assign Bram_PM.En_S   = issue;
    assign Bram_PM.WrEn_S = '0;
    assign Bram_PM.Wr_D   = '0;
    assign Bram_PM.Addr_S = {{ADDR_PAD{1'b0}}, issue_cnt_q, 2'b00};

    assign Busy_SO       = (state_q != ST_IDLE);
    assign Done_SO       = (state_q == ST_DONE);
    assign EntryValid_SO = !fifo_empty;
    assign EntryLast_SO  = head_last;
    assign EntryTs_DO    = head_entry.ts;
    assign EntryAddr_DO  = head_entry.addr;
    assign EntryId_DO    = head_entry.id;
    assign EntryLen_DO   = head_entry.len;
    assign State_SO      = state_q;

endmodule

// File: tb/tb_axi_log_reader.sv
// Directed bench for axi_log_reader: BRAM model, driver tasks, and a
// scoreboard monitor that checks every stream beat against an expected queue.
module tb_axi_log_reader;

    localparam int CAP   = 12288;
    localparam int CNT_W = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             clear;
    logic             ready;
    logic [CNT_W-1:0] num;
    logic             busy;
    logic             done;
    logic             valid;
    logic             last;
    logic [31:0]      ts;
    logic [31:0]      addr;
    logic [7:0]       id;
    logic [7:0]       len;
    logic [1:0]       state;

    always #5 clk = ~clk;

    BramPort #(.DATA_WIDTH(96), .ADDR_WIDTH(32)) bram ();

    axi_log_reader dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .Start_SI      (start),
        .NumEntries_DI (num),
        .Clear_SI      (clear),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .Bram_PM       (bram),
        .EntryValid_SO (valid),
        .EntryReady_SI (ready),
        .EntryLast_SO  (last),
        .EntryTs_DO    (ts),
        .EntryAddr_DO  (addr),
        .EntryId_DO    (id),
        .EntryLen_DO   (len),
        .State_SO      (state)
    );

    // ---------------- BRAM model (1-cycle read latency) ----------------
    logic [95:0] mem [0:CAP-1];

    always @(posedge clk) begin
        if (bram.En_S) bram.Rd_D <= mem[bram.Addr_S[15:2]];
    end

    function automatic logic [95:0] mem_word(input int k);
        logic [31:0] kk;
        logic [31:0] twok;
        kk   = 32'(k);
        twok = 32'(2 * k);
        return {16'hDEAD, twok[7:0], kk[7:0], 32'h1000 + kk, kk};
    endfunction

    function automatic logic [80:0] exp_word(input int k, input bit is_last);
        logic [31:0] kk;
        logic [31:0] twok;
        kk   = 32'(k);
        twok = 32'(2 * k);
        return {kk, 32'h1000 + kk, kk[7:0], twok[7:0], is_last};
    endfunction

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run_base = 0;
    int          en_cnt = 0;
    int          pop_cnt = 0;
    int          vld_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [80:0] exp_q [$];
    int          exp_cyc_q [$];
    int          exp_done_q [$];

    logic        prev_stall = 1'b0;
    logic [80:0] prev_w = '0;
    logic [80:0] w;
    int          rel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            rel = cyc - run_base;
            if (start && state == 2'd0) begin
                en_cnt  = 0;
                pop_cnt = 0;
                vld_cnt = 0;
            end
            if (bram.En_S) begin
                en_cnt++;
                last_addr = bram.Addr_S;
            end
            if (valid) vld_cnt++;
            w = {ts, addr, id, len, last};
            if (prev_stall) begin
                check("stall_valid", 128'(valid), 128'(1'b1));
                check("stall_fields", 128'(w), 128'(prev_w));
            end
            if (valid && ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none (cycle %0d)", w, cyc);
                end else begin
                    check("beat", 128'(w), 128'(exp_q.pop_front()));
                end
                if (exp_cyc_q.size() > 0) check("beat_cycle", 128'(rel), 128'(exp_cyc_q.pop_front()));
            end
            if (state != 2'd0) check("credit", 128'(en_cnt - pop_cnt <= 2), 128'(1'b1));
            if (done) begin
                done_cnt++;
                check("done_busy", 128'(busy), 128'(1'b1));
                if (exp_done_q.size() > 0) check("done_cycle", 128'(rel), 128'(exp_done_q.pop_front()));
            end
            prev_stall = valid && !ready && !clear;
            prev_w     = w;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input int n, input bit hold);
        @(posedge clk);
        #1;
        num      = CNT_W'(n);
        start    = 1'b1;
        run_base = cyc;
        @(posedge clk);
        #1;
        if (hold) num = CNT_W'(5);
        else      start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        bit seen;
        int ph;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (toggle) begin
                @(posedge clk);
                #1;
                ph    = i % 4;
                ready = (ph == 0) || (ph == 3);
            end
        end
        check("done_seen", 128'(seen), 128'(1'b1));
    endtask

    task automatic post_done();
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 128'(busy), 128'(1'b0));
        check("done_one_cycle", 128'(done), 128'(1'b0));
        check("exp_q_drained", 128'(exp_q.size()), 128'(0));
        check("exp_done_drained", 128'(exp_done_q.size()), 128'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_done"}, 128'(done), 128'(1'b0));
        check({tag, "_valid"}, 128'(valid), 128'(1'b0));
        check({tag, "_last"}, 128'(last), 128'(1'b0));
        check({tag, "_fields"}, 128'({ts, addr, id, len}), 128'(0));
        check({tag, "_en"}, 128'(bram.En_S), 128'(1'b0));
        check({tag, "_wren"}, 128'(bram.WrEn_S), 128'(0));
        check({tag, "_state"}, 128'(state), 128'(0));
    endtask

    task automatic push_beats(input int n, input int total, input bit timed);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(exp_word(k, k == total - 1));
            if (timed) exp_cyc_q.push_back(k + 3);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int d0;

    initial begin
        for (int k = 0; k < CAP; k++) mem[k] = mem_word(k);
        rst   = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        ready = 1'b0;
        num   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // N=4, ready held high: beats in cycles 3..6, Done in cycle 7
        ready = 1'b1;
        push_beats(4, 4, 1'b1);
        exp_done_q.push_back(7);
        start_run(4, 1'b0);
        @(negedge clk);
        check("c1_busy", 128'(busy), 128'(1'b1));
        check("c1_en", 128'(bram.En_S), 128'(1'b1));
        check("c1_addr", 128'(bram.Addr_S), 128'(0));
        check("c1_valid", 128'(valid), 128'(1'b0));
        wait_done(50, 1'b0);
        post_done();

        // N=4 with ready toggling 1,0,0,1
        ready = 1'b1;
        push_beats(4, 4, 1'b0);
        start_run(4, 1'b0);
        wait_done(60, 1'b1);
        check("stalls_seen", 128'(vld_cnt > 4), 128'(1'b1));
        check("toggle_issued", 128'(en_cnt), 128'(4));
        ready = 1'b1;
        post_done();

        // N=0: Done in cycle 1, no BRAM access, no beats
        exp_done_q.push_back(1);
        start_run(0, 1'b0);
        wait_done(10, 1'b0);
        post_done();
        check("n0_no_en", 128'(en_cnt), 128'(0));
        check("n0_no_valid", 128'(vld_cnt), 128'(0));

        // Full capacity
        ready = 1'b1;
        push_beats(CAP, CAP, 1'b0);
        exp_done_q.push_back(CAP + 3);
        start_run(CAP, 1'b0);
        wait_done(CAP + 100, 1'b0);
        check("cap_last_addr", 128'(last_addr), 128'(32'hBFFC));
        check("cap_issued", 128'(en_cnt), 128'(CAP));
        post_done();
        repeat (3) @(negedge clk);
        check("cap_no_wrap", 128'(en_cnt), 128'(CAP));

        // Clear in cycle 4 of an N=8 run
        d0 = done_cnt;
        push_beats(2, 8, 1'b0);
        start_run(8, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_valid", 128'(valid), 128'(1'b0));
        check("clr_state", 128'(state), 128'(0));
        check("clr_busy", 128'(busy), 128'(1'b0));
        repeat (4) @(negedge clk);
        check("clr_no_done", 128'(done_cnt), 128'(d0));
        check("clr_exp_q", 128'(exp_q.size()), 128'(0));

        // Fresh N=2 after clear
        push_beats(2, 2, 1'b1);
        exp_done_q.push_back(5);
        start_run(2, 1'b0);
        wait_done(30, 1'b0);
        post_done();

        // Start held high (with a different count) while busy is ignored
        push_beats(2, 2, 1'b1);
        exp_done_q.push_back(5);
        start_run(2, 1'b1);
        wait_done(30, 1'b0);
        post_done();
        check("hold_issued", 128'(en_cnt), 128'(2));

        // Reset in the middle of a stalled run
        ready = 1'b0;
        start_run(8, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pre_rst_valid", 128'(valid), 128'(1'b1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");

        // Normal N=3 run after reset
        ready = 1'b1;
        push_beats(3, 3, 1'b1);
        exp_done_q.push_back(6);
        start_run(3, 1'b0);
        wait_done(30, 1'b0);
        post_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_log_reader.md
# axi_log_reader

Drains entries written by the AXI BRAM logger out of the port-B side of its true-dual-port BRAM array and presents them as decoded records on a valid/ready stream. It is the read-side counterpart of the logger: software or a DMA front-end issues a start with an entry count, and the block fetches each 96-bit entry and splits it into timestamp, AXI address, ID and burst length. A 2-entry output buffer covers the BRAM read latency and sustains one entry per cycle under continuous ready.

## Interface
Parameters:
- `AXI_ADDR_BITW`, 32, logged AXI address width.
- `AXI_ID_BITW`, 8, logged AXI ID width.
- `AXI_LEN_BITW`, 8, logged AXI length width.
- `TIMESTAMP_BITW`, 32, logged timestamp width.
- `LOGGING_DATA_BITW`, 96, entry width.
- `NUM_SER_BRAMS`, 12, serial BRAM count.
- Capacity is `1024*NUM_SER_BRAMS` entries (derived).

Ports:
- One clock; reset is synchronous and active-high.
- `Clk_CI`  in  1  clock.
- `Rst_RI`  in  1  synchronous active-high reset.
- `Start_SI`  in  1  start a readout; sampled only in IDLE.
- `NumEntries_DI`  in  log2(capacity)+1  number of entries to read, 0..capacity.
- `Clear_SI`  in  1  abort the readout and flush.
- `Busy_SO`  out  1  high from start acceptance until Done.
- `Done_SO`  out  1  one-cycle completion pulse.
- `Bram_PM`  master  BramPort (`DATA_WIDTH`=`LOGGING_DATA_BITW`, `ADDR_WIDTH`=32)  read port. Write enable is always 0; `Rst_R` is driven from `Rst_RI`.
- `EntryValid_SO`  out  1  stream valid.
- `EntryReady_SI`  in  1  stream ready.
- `EntryLast_SO`  out  1  marks the final entry.
- `EntryTs_DO`  out  `TIMESTAMP_BITW`  bits [31:0] of the entry.
- `EntryAddr_DO`  out  `AXI_ADDR_BITW`  bits [63:32].
- `EntryId_DO`  out  `AXI_ID_BITW`  bits [64+ID-1:64].
- `EntryLen_DO`  out  `AXI_LEN_BITW`  the next `AXI_LEN_BITW` bits above the ID.

## Operation
- **FSM states:** IDLE, FETCH, DRAIN, DONE.
  - IDLE → FETCH on `Start_SI` when `NumEntries_DI` is non-zero.
  - IDLE → DONE on `Start_SI` when `NumEntries_DI` is 0.
  - FETCH → DRAIN once all reads are issued.
  - DRAIN → DONE once the buffer is empty and nothing is in flight.
  - DONE → IDLE after one cycle.
- **`Start_SI` outside IDLE:** ignored.
- **Count latching:** `NumEntries_DI` is latched on start.
- **Read addressing:**
  - Read index k uses byte address `k<<2` on `Bram_PM.Addr_S`. Upper bits are 0.
  - `En_S` is all-ones only in cycles where a read is issued.
- **Credit rule:** a read is issued only while (buffer occupancy + reads in flight, after any same-cycle pop) < 2. No entry is ever dropped.
- **Issue counter:** counts 0..N−1 and stops at N; it never wraps.
- **`EntryLast_SO`:** asserted on the entry whose index equals N−1.
- **Output stability:** output fields are stable while `EntryValid_SO` is high and `EntryReady_SI` is low.
- **`Clear_SI` in any non-IDLE state:**
  - Buffer flushed; in-flight data discarded.
  - Next state IDLE; no Done pulse.
  - `Clear_SI` in IDLE has no effect.
- **Bit-packing:** bits above `EntryLen` in the entry are ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0, buffer empty, `Bram_PM.En_S` 0.
- **Start latency:** start sampled at edge 0.
  - Cycle 1: `Busy_SO`=1 and the first read (addr 0) is issued.
  - Cycle 2: BRAM data returns and is captured at the end of the cycle.
  - Cycle 3: `EntryValid_SO`=1.
- **Throughput:** with `EntryReady_SI` held high, one entry per cycle. N entries complete their last handshake in cycle N+2.
- **Done:** `Done_SO` pulses in the cycle after the last handshake, with `Busy_SO` still 1 in that cycle. `Busy_SO`=0 in the following cycle.
- **N=0:** `Done_SO` pulses in cycle 1 with `Busy_SO`=1, and no BRAM access occurs.
- **Simultaneous `Clear_SI` and last handshake:** Clear wins; no Done pulse.
- **Reset mid-operation:** on the next edge, everything returns to reset values.

## Structure
- **Shared package `axi_log_pkg`:**
  - Bit-position constants for the entry fields (`TS_LOW`, `ADDR_LOW`, `ID_LOW`, `LEN_LOW`), shared with the logger.
  - Packed struct `log_entry_t`.
  - FSM enum type.
- **Sub-module `log_entry_fifo`:** a 2-deep first-word-fall-through register buffer carrying `{log_entry_t, last}`, with push, pop, full, empty and a count output.

## Test plan
- Preload entries 0..3 with TS=k, ADDR=0x1000+k, ID=k, LEN=2k, then start with N=4 and ready=1 → four beats in cycles 3..6 with matching fields, Last on beat 3, Done in cycle 7.
- N=4 with ready toggled 1,0,0,1,… → fields stable under stall, no loss or duplication, and at most 2 reads outstanding plus buffered at any cycle.
- N=0 → Done pulses in cycle 1, no `En_S` activity, no valid output.
- N=capacity (12288) with ready=1 → last address is 0xBFFC, Last on the final beat, and the counter does not wrap.
- `Clear_SI` asserted in cycle 4 of an N=8 run → valid drops in cycle 5, state IDLE, no Done; a fresh start with N=2 then works normally.
- `Rst_RI` asserted mid-run → all outputs 0 at the next edge; `Start_SI` held during Busy is ignored.
